// File: rtl/jogo_pkg.sv
// Shared definitions for the game input path: FSM state codes, button codes
// and the one-hot validity check.
package jogo_pkg;

  typedef enum logic [3:0] {
    ESPERA         = 4'b0000,
    FILTRA_PRESS   = 4'b0001,
    REGISTRA       = 4'b0010,
    AGUARDA_SOLTAR = 4'b0011,
    FILTRA_SOLT    = 4'b0100
  } estado_t;

  localparam logic [3:0] NENHUM  = 4'b0000;
  localparam logic [3:0] BOTAO_0 = 4'b0001;
  localparam logic [3:0] BOTAO_1 = 4'b0010;
  localparam logic [3:0] BOTAO_2 = 4'b0100;
  localparam logic [3:0] BOTAO_3 = 4'b1000;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != NENHUM) && ((v & (v - 4'd1)) == NENHUM);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared by synchronous reset.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/detector_jogada_botoes.sv
// Synchronizes, debounces and validates the four buttons, emitting one pulse per press.
// Optional: DETECTOR_MULTIPLO_ERRO_EN adds db_multiplo (multi-button press flag).
module detector_jogada_botoes
  import jogo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic [3:0] db_estado
`ifdef DETECTOR_MULTIPLO_ERRO_EN
  , output logic     db_multiplo
`endif
);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  estado_t          estado, estado_prox;
  logic [3:0]       s2, candidato, candidato_prox;
  logic [CNT_W-1:0] cnt, cnt_prox;

  sincronizador_2ff #(.WIDTH(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s2)
  );

  // jogada is loaded as REGISTRA is entered so it is valid alongside the pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= ESPERA;
      cnt       <= '0;
      candidato <= '0;
      jogada    <= '0;
    end else begin
      estado    <= estado_prox;
      cnt       <= cnt_prox;
      candidato <= candidato_prox;
      if (estado_prox == REGISTRA)
        jogada <= candidato;
    end
  end

  always_comb begin
    estado_prox    = estado;
    cnt_prox       = cnt;
    candidato_prox = candidato;
    case (estado)
      ESPERA: begin
        if (s2 != NENHUM) begin
          candidato_prox = s2;
          cnt_prox       = '0;
          estado_prox    = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (s2 != candidato)
          estado_prox = ESPERA;
        else if (cnt == CNT_FIM)
          estado_prox = (eh_one_hot(candidato) && habilita) ? REGISTRA : AGUARDA_SOLTAR;
        else
          cnt_prox = cnt + CNT_W'(1);
      end
      REGISTRA: estado_prox = AGUARDA_SOLTAR;
      AGUARDA_SOLTAR: begin
        if (s2 == NENHUM) begin
          cnt_prox    = '0;
          estado_prox = FILTRA_SOLT;
        end
      end
      FILTRA_SOLT: begin
        if (s2 != NENHUM)
          estado_prox = AGUARDA_SOLTAR;
        else if (cnt == CNT_FIM)
          estado_prox = ESPERA;
        else
          cnt_prox = cnt + CNT_W'(1);
      end
      default: estado_prox = ESPERA;
    endcase
  end

  always_comb begin
    tem_jogada = (estado == REGISTRA);
    db_estado  = estado;
  end

`ifdef DETECTOR_MULTIPLO_ERRO_EN
  always_ff @(posedge clock) begin
    if (reset)
      db_multiplo <= 1'b0;
    else
      db_multiplo <= (estado == FILTRA_PRESS) && (estado_prox == AGUARDA_SOLTAR)
                     && !eh_one_hot(candidato);
  end
`endif

endmodule

// File: tb/tb_detector_jogada_botoes.sv
// Directed bench: per-cycle comparison against a press/release behavioural model.
module tb_detector_jogada_botoes;
  import jogo_pkg::*;

  localparam int unsigned D = 2;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic [3:0] db_estado;
`ifdef DETECTOR_MULTIPLO_ERRO_EN
  logic       db_multiplo;
`endif

  detector_jogada_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .jogada     (jogada),
    .tem_jogada (tem_jogada),
    .db_estado  (db_estado)
`ifdef DETECTOR_MULTIPLO_ERRO_EN
    , .db_multiplo (db_multiplo)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          ciclo       = 0;
  int          pulsos      = 0;
  int          pulso_ciclo = -1;

  // Model: the press is confirmed once the synchronized code repeats D more
  // times unchanged; after any accepted/rejected press, D+1 quiet samples re-arm.
  logic [3:0] s1m, s2m, amostra, cand_m, jog_m;
  logic       pulse_m, armado, tentando, modelo_ok = 1'b0;
  int         conf, quieto;

  always @(posedge clock) begin
    ciclo++;
    modelo_ok = 1'b1;
    if (reset) begin
      s1m = '0; s2m = '0; jog_m = '0; cand_m = '0;
      pulse_m = 1'b0; armado = 1'b1; tentando = 1'b0; conf = 0; quieto = 0;
    end else begin
      amostra = s2m;
      if (pulse_m)
        pulse_m = 1'b0;
      else if (!armado) begin
        if (amostra == 4'b0000) begin
          quieto++;
          if (quieto == D + 1) armado = 1'b1;
        end else
          quieto = 0;
      end else if (tentando) begin
        if (amostra != cand_m)
          tentando = 1'b0;
        else begin
          conf++;
          if (conf == D) begin
            tentando = 1'b0;
            armado   = 1'b0;
            quieto   = 0;
            if ($countones(cand_m) == 1 && habilita) begin
              jog_m   = cand_m;
              pulse_m = 1'b1;
            end
          end
        end
      end else if (amostra != 4'b0000) begin
        tentando = 1'b1;
        cand_m   = amostra;
        conf     = 0;
      end
      s2m = s1m;
      s1m = botoes;
    end
  end

  always @(negedge clock) begin
    if (modelo_ok) begin
      vectors++;
      if (jogada !== jog_m || tem_jogada !== pulse_m) begin
        miscompares++;
        $display("FAIL model cycle %0d: jogada=%b tem_jogada=%b, expected jogada=%b tem_jogada=%b",
                 ciclo, jogada, tem_jogada, jog_m, pulse_m);
      end
      if (tem_jogada === 1'b1) begin
        pulsos++;
        pulso_ciclo = ciclo;
      end
    end
  end

  task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    vectors++;
    if (atual !== esperado) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic aplica(input logic [3:0] b, input int unsigned n);
    botoes = b;
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int base, t0;
    reset = 1'b1; botoes = NENHUM; habilita = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    confere("reset_estado", 32'(db_estado), 32'h0);
    confere("reset_jogada", 32'(jogada), 32'h0);
    confere("reset_tem", 32'(tem_jogada), 32'h0);

    // clean 5-period press
    base = pulsos; t0 = ciclo + 1;
    aplica(BOTAO_2, 5); aplica(NENHUM, 8);
    confere("press5_pulsos", 32'(pulsos - base), 32'd1);
    confere("press5_latencia", 32'(pulso_ciclo - t0), 32'd4);
    confere("press5_jogada", 32'(jogada), 32'b0100);

    // 2-period glitch rejected
    base = pulsos;
    aplica(BOTAO_0, 2); aplica(NENHUM, 8);
    confere("glitch_pulsos", 32'(pulsos - base), 32'd0);
    confere("glitch_jogada", 32'(jogada), 32'b0100);

    // minimum accepted width D+1
    base = pulsos;
    aplica(BOTAO_0, 3); aplica(NENHUM, 8);
    confere("minwidth_pulsos", 32'(pulsos - base), 32'd1);
    confere("minwidth_jogada", 32'(jogada), 32'b0001);

    // bounce then stable
    base = pulsos;
    aplica(BOTAO_1, 1); aplica(NENHUM, 1); aplica(BOTAO_1, 6); aplica(NENHUM, 8);
    confere("bounce_pulsos", 32'(pulsos - base), 32'd1);
    confere("bounce_jogada", 32'(jogada), 32'b0010);

    // long hold, short release, debounced release
    base = pulsos;
    aplica(BOTAO_3, 20);
    confere("hold_pulsos", 32'(pulsos - base), 32'd1);
    aplica(NENHUM, 1); aplica(BOTAO_3, 5);
    confere("shortrel_pulsos", 32'(pulsos - base), 32'd1);
    aplica(NENHUM, 4); aplica(BOTAO_3, 5); aplica(NENHUM, 8);
    confere("rel4_pulsos", 32'(pulsos - base), 32'd2);
    confere("rel4_jogada", 32'(jogada), 32'b1000);

    // two buttons
    base = pulsos;
    aplica(4'b0011, 5); aplica(NENHUM, 8);
    confere("multi_pulsos", 32'(pulsos - base), 32'd0);
    confere("multi_jogada", 32'(jogada), 32'b1000);

    // habilita low swallows the press
    base = pulsos;
    habilita = 1'b0;
    aplica(BOTAO_0, 5); aplica(NENHUM, 8);
    habilita = 1'b1;
    aplica(NENHUM, 2);
    confere("hab0_pulsos", 32'(pulsos - base), 32'd0);
    confere("hab0_jogada", 32'(jogada), 32'b1000);

    // reset while filtering a press
    base = pulsos;
    botoes = BOTAO_2;
    repeat (3) @(posedge clock);
    @(negedge clock);
    confere("filtra_estado", 32'(db_estado), 32'b0001);
    reset = 1'b1; botoes = NENHUM;
    @(posedge clock);
    @(negedge clock);
    confere("rst_mid_estado", 32'(db_estado), 32'h0);
    confere("rst_mid_jogada", 32'(jogada), 32'h0);
    confere("rst_mid_tem", 32'(tem_jogada), 32'h0);
    reset = 1'b0;
    aplica(NENHUM, 6);
    confere("rst_mid_pulsos", 32'(pulsos - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
